// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and self-check for a small combinational block
//
// Drives every N_IN-bit input vector in ascending order and holds each one for HOLD cycles.
// On the last hold cycle it compares dut_out against EXPECTED[vec*N_OUT +: N_OUT].
// Optional build macro: STOP_ON_FAIL_EN (end the sweep at the first mismatching vector).
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   begin a sweep (pulse or level; ignored while busy)
//   dut_out          in   N_OUT  DUT outputs, combinational from vec
//   vec              out  N_IN   stimulus to the DUT, vec[N_IN-1] is the MSB
//   busy             out  sweep in progress
//   done             out  sweep finished, held until next start or reset
//   pass             out  done with err_count == 0
//   err_count        out  N_IN+1 number of mismatching vectors
//   first_fail_valid out  at least one mismatch recorded
//   first_fail_vec   out  N_IN   vector of the first mismatch
module truth_table_sweeper #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int HOLD  = 10,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 16'hD668
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int TW = N_OUT * (2**N_IN);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int EW = N_IN + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   table_shift;
  logic [N_OUT-1:0] exp_out;
  logic            mismatch;
  logic            at_last;
  logic            last_vec;
  logic            stop_now;
  logic [EW-1:0]   err_next;

  // Select the expected entry for the current vector by shifting the table down.
  always_comb begin
    table_shift = EXPECTED >> (32'(vec) * N_OUT);
    exp_out     = table_shift[N_OUT-1:0];
    mismatch    = (dut_out != exp_out);
    at_last     = (hold_cnt == HOLD_LAST);
    last_vec    = (vec == {N_IN{1'b1}});
    err_next    = err_count + EW'(mismatch);
`ifdef STOP_ON_FAIL_EN
    stop_now    = last_vec || mismatch;
`else
    stop_now    = last_vec;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      vec              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= RUN;
            vec              <= '0;
            hold_cnt         <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            done             <= 1'b0;
            pass             <= 1'b0;
            busy             <= 1'b1;
          end
        end
        RUN: begin
          if (at_last) begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
            if (stop_now) begin
              // vec is left on the final (or failing) vector for inspection.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              vec      <= vec + N_IN'(1);
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
